mac_rx_stat: RTL
================

// Module: mac_rx_stat
// PURPOSE
//  Per-channel RX frame monitor/statistics for ETHCOUNT mac_rgmii receivers.
//  Generalises the single-channel rx error detector to N channels, adding frame/byte/error counters,
//  length checks, framing checks, sticky flags and a muxed register readout.
//  Sits between the mac_rgmii RX outputs and debug (LED/ILA).
// PARAMETERS
//  ETHCOUNT   1     channels, 1..4
//  CNT_W      32    counter width, 8..32
//  MIN_LEN    64    min legal frame length (bytes, sof..eof inclusive)
//  MAX_LEN    1518  max legal frame length
//  SATURATE   1     1: counters stick at all-ones; 0: wrap to 0
// PORTS
//  clk                  in   1           rx domain clock (mac_gtx_clk)
//  rst                  in   1           sync, active-high
//  mac_rx_axis_tdata    in   8*ETHCOUNT  rx byte per channel (not counted, length only)
//  mac_rx_axis_tvalid   in   ETHCOUNT    byte valid
//  mac_rx_axis_tuser    in   ETHCOUNT    sof, qualified by tvalid
//  mac_rx_axis_tlast    in   ETHCOUNT    eof, qualified by tvalid
//  mac_rx_axis_fr_good  in   ETHCOUNT    frame FCS good, sampled on eof&tvalid
//  mac_rx_axis_fr_err   in   ETHCOUNT    PHY/rx error pulse, any cycle
//  clr                  in   ETHCOUNT    per-channel clear of counters and sticky flags
//  rd_ch                in   2           channel select (>=ETHCOUNT reads 0)
//  rd_sel               in   3           register select, see below
//  rd_data              out  CNT_W       readout, 1-cycle latency
//  err_o                out  ETHCOUNT    per-channel error pulse
//  err_det              out  1           OR of err_o
//  err_sticky           out  ETHCOUNT    sticky any-error flag
// BEHAVIOUR
//  - Reset: all counters, length, in_frame, err_o, err_det, err_sticky, rd_data = 0.
//  - Beat = tvalid; beats without tvalid ignored entirely.
//  - In-frame tracking: sof beat sets in_frame, len=1 (sof&eof same beat = 1-byte frame, closes immediately).
//    Non-sof beat in frame: len+1, saturating at 16'hFFFF.
//  - Frame close on eof beat in frame (len includes the eof byte):
//    good if fr_good=1 and MIN_LEN<=len<=MAX_LEN -> GOOD+1; else -> BAD+1.
//  - Framing errors -> FRAMING+1:
//    sof while in_frame (old frame also counted BAD, new frame starts);
//    eof with in_frame=0 and no sof (no frame counters change);
//    non-sof beat with in_frame=0 (byte not counted).
//  - BYTES+1 on every beat belonging to a frame (sof beat included).
//  - PHYERR+1 on every fr_err=1 cycle; in_frame and len unaffected.
//  - err_o[c]: 2-cycle pipeline. Stage0 registers (bad close | framing error | fr_err);
//    stage1 = err_o. A bad eof at cycle t gives err_o=1 at t+2 for one cycle. err_det same cycle as err_o.
//  - err_sticky[c] sets with stage0, holds until clr[c] or rst.
//  - Counters: CNT_W wide, behaviour at max per SATURATE.
//  - clr[c]: counters, sticky, in_frame, len of channel c -> 0 next cycle.
//    Clear wins over a same-cycle event; that event is not counted. The err pipeline is not flushed.
//  - rd_sel: 0 GOOD, 1 BAD, 2 BYTES, 3 FRAMING, 4 PHYERR,
//    5 STATUS {.., err_sticky, in_frame, last_len[15:0]}, 6-7 read 0.
//    rd_data = register value at cycle t, visible at t+1; a read does not clear.
//  - last_len: length of the most recently closed frame, good or bad.
//  - rst mid-frame: everything to 0; the next sof starts a clean frame.
// STRUCTURE
//  - Header mac_rx_stat_pkg.vh: REG_GOOD..REG_STATUS indices, LEN_W=16, STATUS bit positions.
//  - Sub-module mac_rx_stat_ch (one channel: tracking, counters, err pipeline), generated ETHCOUNT times.
//  - Top level: readout mux, rd_data register, err_det OR.
// TESTING
//  1 ETHCOUNT=2, ch0 100-byte frame, fr_good=1 -> GOOD=1, BYTES=100, last_len=100, err_o[0] stays 0.
//  2 64-byte frame with fr_good=0 on eof at t -> BAD=1, err_o[0]=err_det=1 at t+2 only, err_sticky[0]=1.
//  3 ch1: 63-byte and 1519-byte frames, fr_good=1 -> BAD=2, GOOD=0.
//    Then 1518-byte frame -> GOOD=1. ch0 counters unchanged throughout.
//  4 sof at byte 10 of an open frame, then 70-byte frame -> FRAMING=1, BAD=1, GOOD=1.
//    Then a lone eof -> FRAMING=2.
//  5 CNT_W=8, SATURATE=1, 300 good frames -> GOOD=255. SATURATE=0 -> GOOD=44.
//  6 clr[0] on the same cycle as a good eof -> GOOD=0, sticky=0.
//    fr_err pulse with rst mid-frame -> all reads 0 after rst.

Source files
------------

// File: rtl/mac_rx_stat_pkg.sv
// Shared definitions for the RX frame statistics block: register map,
// STATUS word layout, channel tracking states and the frame length check.
package mac_rx_stat_pkg;

    localparam int LEN_W = 16;

    localparam logic [2:0] REG_GOOD    = 3'd0;
    localparam logic [2:0] REG_BAD     = 3'd1;
    localparam logic [2:0] REG_BYTES   = 3'd2;
    localparam logic [2:0] REG_FRAMING = 3'd3;
    localparam logic [2:0] REG_PHYERR  = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam int STAT_LEN_LSB  = 0;
    localparam int STAT_IN_FRAME = 16;
    localparam int STAT_STICKY   = 17;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_e;

    // Inclusive legal-length window test for a closing frame.
    function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                    input int min_len,
                                    input int max_len);
        int l;
        l = int'({{(32-LEN_W){1'b0}}, len});
        return (l >= min_len) && (l <= max_len);
    endfunction

endpackage

// File: rtl/mac_rx_stat_ch.sv
// One RX channel: frame tracking, length/framing checks, statistics
// counters, sticky error flag and a two-stage error pulse pipeline.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_IDLE  | between frames; only a sof beat is legal
//   ST_FRAME | sof seen, counting bytes until the eof beat
module mac_rx_stat_ch
    import mac_rx_stat_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tvalid,
    input  logic             tuser,
    input  logic             tlast,
    input  logic             fr_good,
    input  logic             fr_err,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad,
    output logic [CNT_W-1:0] cnt_bytes,
    output logic [CNT_W-1:0] cnt_framing,
    output logic [CNT_W-1:0] cnt_phyerr,
    output logic [LEN_W-1:0] last_len,
    output logic             in_frame,
    output logic             err_sticky,
    output logic             err_o
);

    rx_state_e        state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt, len_inc, last_len_nxt;
    logic             inc_good, inc_bytes, inc_framing;
    logic [1:0]       inc_bad;
    logic             err_ev, err_s0;

    // A sof that interrupts a frame and is itself a 1-byte bad frame
    // closes two frames in one beat, so BAD may step by two.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        if ((SATURATE != 0) && sum[CNT_W])
            return '1;
        return sum[CNT_W-1:0];
    endfunction

    assign in_frame = (state == ST_FRAME);

    // Decode the current beat into counter increments and next tracking state.
    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        last_len_nxt = last_len;
        len_inc      = (len == '1) ? len : len + 1'b1;
        inc_good     = 1'b0;
        inc_bad      = 2'd0;
        inc_bytes    = 1'b0;
        inc_framing  = 1'b0;
        if (tvalid) begin
            if (tuser) begin
                inc_bytes = 1'b1;
                if (state == ST_FRAME) begin
                    inc_bad      = 2'd1;
                    inc_framing  = 1'b1;
                    last_len_nxt = len;
                end
                len_nxt = LEN_W'(1);
                if (tlast) begin
                    state_nxt    = ST_IDLE;
                    last_len_nxt = LEN_W'(1);
                    if (fr_good && len_ok(LEN_W'(1), MIN_LEN, MAX_LEN))
                        inc_good = 1'b1;
                    else
                        inc_bad = inc_bad + 2'd1;
                end else begin
                    state_nxt = ST_FRAME;
                end
            end else if (state == ST_FRAME) begin
                inc_bytes = 1'b1;
                len_nxt   = len_inc;
                if (tlast) begin
                    state_nxt    = ST_IDLE;
                    last_len_nxt = len_inc;
                    if (fr_good && len_ok(len_inc, MIN_LEN, MAX_LEN))
                        inc_good = 1'b1;
                    else
                        inc_bad = 2'd1;
                end
            end else begin
                inc_framing = 1'b1;
            end
        end
        err_ev = (inc_bad != 2'd0) | inc_framing | fr_err;
    end

    // Tracking, counters and error pipeline; clear drops the same-cycle event
    // but lets an error already in stage0 reach err_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            last_len    <= '0;
            cnt_good    <= '0;
            cnt_bad     <= '0;
            cnt_bytes   <= '0;
            cnt_framing <= '0;
            cnt_phyerr  <= '0;
            err_s0      <= 1'b0;
            err_o       <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            err_o <= err_s0;
            if (clr) begin
                state       <= ST_IDLE;
                len         <= '0;
                last_len    <= '0;
                cnt_good    <= '0;
                cnt_bad     <= '0;
                cnt_bytes   <= '0;
                cnt_framing <= '0;
                cnt_phyerr  <= '0;
                err_s0      <= 1'b0;
                err_sticky  <= 1'b0;
            end else begin
                state       <= state_nxt;
                len         <= len_nxt;
                last_len    <= last_len_nxt;
                cnt_good    <= bump(cnt_good, {1'b0, inc_good});
                cnt_bad     <= bump(cnt_bad, inc_bad);
                cnt_bytes   <= bump(cnt_bytes, {1'b0, inc_bytes});
                cnt_framing <= bump(cnt_framing, {1'b0, inc_framing});
                cnt_phyerr  <= bump(cnt_phyerr, {1'b0, fr_err});
                err_s0      <= err_ev;
                err_sticky  <= err_sticky | err_ev;
            end
        end
    end

endmodule

// File: rtl/mac_rx_stat.sv
// Multi-channel RX frame monitor: one tracker per channel, a registered
// register readout mux and the combined error indication.
module mac_rx_stat
    import mac_rx_stat_pkg::*;
#(
    parameter int ETHCOUNT = 1,
    parameter int CNT_W    = 32,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518,
    parameter int SATURATE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*ETHCOUNT-1:0] mac_rx_axis_tdata,
    input  logic [ETHCOUNT-1:0]   mac_rx_axis_tvalid,
    input  logic [ETHCOUNT-1:0]   mac_rx_axis_tuser,
    input  logic [ETHCOUNT-1:0]   mac_rx_axis_tlast,
    input  logic [ETHCOUNT-1:0]   mac_rx_axis_fr_good,
    input  logic [ETHCOUNT-1:0]   mac_rx_axis_fr_err,
    input  logic [ETHCOUNT-1:0]   clr,
    input  logic [1:0]            rd_ch,
    input  logic [2:0]            rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic [ETHCOUNT-1:0]   err_o,
    output logic                  err_det,
    output logic [ETHCOUNT-1:0]   err_sticky
);

    logic [CNT_W-1:0] cnt_good    [ETHCOUNT];
    logic [CNT_W-1:0] cnt_bad     [ETHCOUNT];
    logic [CNT_W-1:0] cnt_bytes   [ETHCOUNT];
    logic [CNT_W-1:0] cnt_framing [ETHCOUNT];
    logic [CNT_W-1:0] cnt_phyerr  [ETHCOUNT];
    logic [LEN_W-1:0] last_len    [ETHCOUNT];
    logic [ETHCOUNT-1:0] in_frame;
    logic [CNT_W-1:0] rd_nxt;
    logic [31:0]      status;
    logic             tdata_unused;

    // Payload bytes carry no information for the statistics, only their beats do.
    assign tdata_unused = ^mac_rx_axis_tdata;

    for (genvar c = 0; c < ETHCOUNT; c++) begin : g_ch
        mac_rx_stat_ch #(
            .CNT_W    (CNT_W),
            .MIN_LEN  (MIN_LEN),
            .MAX_LEN  (MAX_LEN),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tvalid      (mac_rx_axis_tvalid[c]),
            .tuser       (mac_rx_axis_tuser[c]),
            .tlast       (mac_rx_axis_tlast[c]),
            .fr_good     (mac_rx_axis_fr_good[c]),
            .fr_err      (mac_rx_axis_fr_err[c]),
            .clr         (clr[c]),
            .cnt_good    (cnt_good[c]),
            .cnt_bad     (cnt_bad[c]),
            .cnt_bytes   (cnt_bytes[c]),
            .cnt_framing (cnt_framing[c]),
            .cnt_phyerr  (cnt_phyerr[c]),
            .last_len    (last_len[c]),
            .in_frame    (in_frame[c]),
            .err_sticky  (err_sticky[c]),
            .err_o       (err_o[c])
        );
    end

    assign err_det = |err_o;

    // Select the addressed register; unpopulated channels and selects read 0.
    always_comb begin
        rd_nxt = '0;
        status = '0;
        for (int c = 0; c < ETHCOUNT; c++) begin
            if (rd_ch == 2'(c)) begin
                status                        = '0;
                status[STAT_STICKY]           = err_sticky[c];
                status[STAT_IN_FRAME]         = in_frame[c];
                status[STAT_LEN_LSB +: LEN_W] = last_len[c];
                case (rd_sel)
                    REG_GOOD:    rd_nxt = cnt_good[c];
                    REG_BAD:     rd_nxt = cnt_bad[c];
                    REG_BYTES:   rd_nxt = cnt_bytes[c];
                    REG_FRAMING: rd_nxt = cnt_framing[c];
                    REG_PHYERR:  rd_nxt = cnt_phyerr[c];
                    REG_STATUS:  rd_nxt = status[CNT_W-1:0];
                    default:     rd_nxt = '0;
                endcase
            end
        end
    end

    // Readout register gives a fixed one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= rd_nxt;
    end

endmodule
